// File: rtl/ntt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ntt_ctrl_pkg
// Shared definitions for the NTT stage sequencer: the sequencer state encoding
// and the default pass geometry (N = 1024: 10 stages of 64 16-point groups).
// No ports; imported by the interface, the top and its sub-module.
// -----------------------------------------------------------------------------
package ntt_ctrl_pkg;

    localparam int DEF_NUM_STAGE        = 10;
    localparam int DEF_GROUPS_PER_STAGE = 64;
    localparam int DEF_PE_LAT           = 6;
    localparam int DEF_DRAIN_CYC        = 8;
    localparam int DEF_TIMEOUT          = 1023;
    localparam int DEF_D_WIDTH          = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// ntt_stage_ctrl_if
// Bundles the host handshake, the AGU-path handshake and the memory-side
// controls of the NTT stage sequencer.
//   master : the sequencer (drives agu_enable, rd_en, wr_en, mem_sel,
//            stage_idx, busy, done, err; receives start and the AGU signals)
//   slave  : the surrounding host/AGU side (the mirror image)
// -----------------------------------------------------------------------------
interface ntt_stage_ctrl_if
    import ntt_ctrl_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
);

    logic               start;
    logic               agu_bn_ma_out_en;
    logic               agu_done_out;
    logic [D_WIDTH-1:0] agu_l;
    logic               agu_enable;
    logic               rd_en;
    logic               wr_en;
    logic               mem_sel;
    logic [D_WIDTH-1:0] stage_idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, agu_bn_ma_out_en, agu_done_out, agu_l,
        output agu_enable, rd_en, wr_en, mem_sel, stage_idx, busy, done, err
    );

    modport slave (
        output start, agu_bn_ma_out_en, agu_done_out, agu_l,
        input  agu_enable, rd_en, wr_en, mem_sel, stage_idx, busy, done, err
    );

endinterface

// File: rtl/ntt_ctrl_delay_line.sv
// -----------------------------------------------------------------------------
// ntt_ctrl_delay_line
// DEPTH-deep 1-bit shift register with asynchronous active-low clear. Turns
// the bank read strobe into the butterfly write-back strobe.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low clear (flushes in-flight writes)
//   i_din  in  strobe entering the pipeline
//   o_dout out i_din delayed DEPTH cycles
//   o_busy out any strobe still in flight (including o_dout)
// -----------------------------------------------------------------------------
module ntt_ctrl_delay_line
    import ntt_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_PE_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_dout,
    output logic o_busy
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= i_din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[DEPTH-2:0], i_din};
            end
        end
    endgenerate

    assign o_dout = r_sr[DEPTH-1];
    assign o_busy = |r_sr;

endmodule

// File: rtl/ntt_stage_ctrl.sv
// -----------------------------------------------------------------------------
// ntt_stage_ctrl
// Pass-level sequencer for the NTT address-generation path. Runs NUM_STAGE
// stages; each stage kicks the AGU, counts the groups it emits, waits for its
// end-of-stage pulse and drains the butterfly pipeline before the next stage.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset (aborts a pass, no done pulse)
//   ctrl_bus     ntt_stage_ctrl_if.master:
//            start, agu_bn_ma_out_en, agu_done_out, agu_l  (inputs)
//            agu_enable, rd_en, wr_en, mem_sel, stage_idx,
//            busy, done, err                               (outputs)
// -----------------------------------------------------------------------------
module ntt_stage_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int NUM_STAGE        = DEF_NUM_STAGE,
    parameter int GROUPS_PER_STAGE = DEF_GROUPS_PER_STAGE,
    parameter int PE_LAT           = DEF_PE_LAT,
    parameter int DRAIN_CYC        = DEF_DRAIN_CYC,
    parameter int TIMEOUT          = DEF_TIMEOUT,
    parameter int D_WIDTH          = DEF_D_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    ntt_stage_ctrl_if.master  ctrl_bus
);

    // One spare bit lets an over-count be seen instead of wrapping to a match.
    localparam int GC_W = $clog2(GROUPS_PER_STAGE) + 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int DC_W = $clog2(DRAIN_CYC + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [D_WIDTH-1:0] r_stage_idx;
    logic               r_mem_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_agu_enable;
    logic [GC_W-1:0]    r_group_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [DC_W-1:0]    r_drain_cnt;

    logic               w_rd_en;
    logic               w_wr_en;
    logic               w_pipe_busy;
    logic               w_timeout;
    logic               w_drain_exit;
    logic               w_last_stage;
    logic               w_stage_bad;

    function automatic logic [GC_W-1:0] sat_inc(input logic [GC_W-1:0] v);
        return (&v) ? v : v + GC_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_timeout    = 1'b0;
        w_drain_exit = 1'b0;
        w_last_stage = (r_stage_idx == D_WIDTH'(NUM_STAGE - 1));
        w_stage_bad  = (r_group_cnt != GC_W'(GROUPS_PER_STAGE)) ||
                       (ctrl_bus.agu_l != r_stage_idx);
        case (r_state)
            ST_IDLE: begin
                if (ctrl_bus.start) w_next_state = ST_KICK;
            end
            ST_KICK: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_rd_en   = ctrl_bus.agu_bn_ma_out_en;
                w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));
                // A proper end-of-stage wins over a simultaneous timeout.
                if (ctrl_bus.agu_done_out) w_next_state = ST_DRAIN;
                else if (w_timeout)        w_next_state = ST_DONE;
            end
            ST_DRAIN: begin
                // The idle counter only runs once no write is left in flight.
                w_drain_exit = !w_pipe_busy && (r_drain_cnt == DC_W'(DRAIN_CYC - 1));
                if (w_drain_exit) w_next_state = w_last_stage ? ST_DONE : ST_KICK;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_idx  <= '0;
            r_mem_sel    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_agu_enable <= 1'b0;
            r_group_cnt  <= '0;
            r_to_cnt     <= '0;
            r_drain_cnt  <= '0;
        end else begin
            // agu_enable lands in the first RUN cycle; done coincides with DONE.
            r_agu_enable <= (r_state == ST_KICK);
            r_done       <= (w_next_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_bus.start) begin
                        r_stage_idx <= '0;
                        r_mem_sel   <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_KICK: begin
                    r_group_cnt <= '0;
                    r_to_cnt    <= '0;
                    r_drain_cnt <= '0;
                end
                ST_RUN: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_rd_en) r_group_cnt <= sat_inc(r_group_cnt);
                    if (w_timeout && !ctrl_bus.agu_done_out) r_err <= 1'b1;
                end
                ST_DRAIN: begin
                    r_drain_cnt <= w_pipe_busy ? '0 : r_drain_cnt + DC_W'(1);
                    if (w_drain_exit) begin
                        if (w_stage_bad) r_err <= 1'b1;
                        if (!w_last_stage) begin
                            r_stage_idx <= r_stage_idx + D_WIDTH'(1);
                            r_mem_sel   <= ~r_mem_sel;
                        end
                    end
                end
                default: ;
            endcase
            if (w_next_state == ST_DONE) r_busy <= 1'b0;
        end
    end

    ntt_ctrl_delay_line #(
        .DEPTH (PE_LAT)
    ) u_wr_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (w_rd_en),
        .o_dout (w_wr_en),
        .o_busy (w_pipe_busy)
    );

    assign ctrl_bus.agu_enable = r_agu_enable;
    assign ctrl_bus.rd_en      = w_rd_en;
    assign ctrl_bus.wr_en      = w_wr_en;
    assign ctrl_bus.mem_sel    = r_mem_sel;
    assign ctrl_bus.stage_idx  = r_stage_idx;
    assign ctrl_bus.busy       = r_busy;
    assign ctrl_bus.done       = r_done;
    assign ctrl_bus.err        = r_err;

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Top-level sequencer for the address-generation path. It runs one full NTT pass as NUM_STAGE consecutive stages.
- Per stage it pulses agu_enable, counts the bank/address groups the AGU path emits, waits for agu_done_out, then drains the butterfly pipeline before starting the next stage.
- It drives the ping-pong buffer select, the write-enable pipeline, and the pass-level start/busy/done/error handshake for the host FSM.

Parameters:
- NUM_STAGE, 10, NTT stages per pass (log2 N).
- GROUPS_PER_STAGE, 64, 16-point groups emitted per stage (N/16).
- PE_LAT, 6, cycles from address group to butterfly write-back.
- DRAIN_CYC, 8, idle cycles after last write before next stage (>= PE_LAT).
- TIMEOUT, 1023, max cycles in WAIT_AGU before error.
- D_WIDTH, 5, width of stage index (matches `D_width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a pass when IDLE.
- agu_bn_ma_out_en  in  1  AGU path output-valid (one group per high cycle).
- agu_done_out  in  1  AGU path end-of-stage pulse.
- agu_l  in  D_WIDTH  stage index echoed by the AGU path.
- agu_enable  out  1  stage kick to the AGU path.
- rd_en  out  1  bank read enable (= agu_bn_ma_out_en while in RUN).
- wr_en  out  1  rd_en delayed PE_LAT cycles.
- mem_sel  out  1  ping-pong select: 0 = read A / write B.
- stage_idx  out  D_WIDTH  current stage, 0..NUM_STAGE-1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at pass end.
- err  out  1  sticky error; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n low): every output 0, state IDLE, all counters 0, wr_en shift register cleared.
- States:
  - IDLE: on start, go to KICK; stage_idx <= 0, mem_sel <= 0, err <= 0, busy <= 1. start while not IDLE is ignored.
  - KICK: agu_enable = 1 for exactly one cycle; group_cnt <= 0, to_cnt <= 0; next state RUN.
  - RUN:
    - Each cycle with agu_bn_ma_out_en, group_cnt++ and rd_en = 1.
    - On agu_done_out, go to DRAIN. agu_done_out in the same cycle as the last valid counts that valid first.
    - to_cnt++ every cycle in RUN; reaching TIMEOUT sets err and goes to DONE.
  - DRAIN:
    - Count DRAIN_CYC cycles after the last wr_en. wr_en keeps shifting, so writes from the last groups still occur here.
    - At exit, check: group_cnt != GROUPS_PER_STAGE or agu_l != stage_idx sets err.
    - If stage_idx == NUM_STAGE-1, go to DONE. Else stage_idx++, mem_sel toggles, go to KICK.
  - DONE: done = 1 for one cycle, busy = 0, back to IDLE. err persists.
- Latency:
  - start to agu_enable: 2 cycles.
  - Minimum stage period: 1 + RUN length + PE_LAT + DRAIN_CYC.
- group_cnt saturates at 2^(log2(GROUPS_PER_STAGE)+1)-1; no wrap.
- agu_bn_ma_out_en outside RUN: ignored, rd_en stays 0, no count.
- agu_done_out outside RUN: ignored.
- mem_sel is stable for a whole stage. It toggles only on the DRAIN to KICK transition.
- rst_n asserted mid-pass aborts immediately; no done pulse, wr_en pipeline flushed.

Decomposition:
- Package ntt_ctrl_pkg: state enum (IDLE, KICK, RUN, DRAIN, DONE) and the default constants above.
- Sub-module: ntt_ctrl_delay_line, a PE_LAT-deep 1-bit shift register with async active-low clear, producing wr_en.

Test Plan:
- Nominal pass (NUM_STAGE=3, GROUPS=4): start; model emits 4 valids then done per stage -> 3 agu_enable pulses, mem_sel 0,1,0, wr_en mirrors rd_en 6 cycles later, single done, err=0.
- Group mismatch: stage 1 emits 3 valids -> err=1 after stage 1 DRAIN; pass completes, done pulses.
- Timeout (TIMEOUT=20): no agu_done_out -> err=1 at RUN cycle 20, done next cycle, busy=0.
- Stage-index mismatch: agu_l=5 while stage_idx=0 -> err=1.
- Reset mid-RUN in stage 1: rst_n low -> all outputs 0 asynchronously; new start restarts at stage_idx=0, mem_sel=0.
- Start during busy plus stray valid in DRAIN -> no restart, group_cnt unchanged, results identical to nominal.
